// File: rtl/capture_pkg.sv
// Shared types, register map and trigger helper for the ping-pong capture block.
// Address constants are 16-bit host addresses; the reset CTRL value is enabled, rising edge.
package capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        TRIG_FREE   = 2'd0,
        TRIG_RISE   = 2'd1,
        TRIG_FALL   = 2'd2,
        TRIG_EITHER = 2'd3
    } trig_mode_t;

    localparam logic [15:0] ADDR_STATUS  = 16'h4000;
    localparam logic [15:0] ADDR_LOCK    = 16'h4001;
    localparam logic [15:0] ADDR_CTRL    = 16'h4002;
    localparam logic [15:0] ADDR_OVERRUN = 16'h4003;

    localparam logic [2:0] CTRL_RESET = 3'b101;

    function automatic logic edge_match(input trig_mode_t mode, input logic cur, input logic prev);
        case (mode)
            TRIG_FREE: return 1'b1;
            TRIG_RISE: return cur & ~prev;
            TRIG_FALL: return ~cur & prev;
            default:   return cur ^ prev;
        endcase
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle latency).
// No backpressure; the read register holds its value when re is low.
module sdp_ram #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/multi_channel_pingpong_capture.sv
// Multi-channel triggered double-buffer capture with host register/buffer bus.
// Host reads return one cycle after bus_en; samples arriving while a locked frame is held count as overruns.
module multi_channel_pingpong_capture
    import capture_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int ADC_WIDTH  = 12,
    parameter int DATA_WIDTH = 16,
    parameter int BUF_DEPTH  = 1024,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sample_en,
    input  logic [NUM_CH*ADC_WIDTH-1:0]   adc_data,
    input  logic                          trig_in,
    input  logic                          stable,
    input  logic                          bus_en,
    input  logic                          bus_we,
    input  logic [ADDR_WIDTH-1:0]         bus_addr,
    input  logic [DATA_WIDTH-1:0]         bus_wdata,
    output logic [DATA_WIDTH-1:0]         bus_rdata,
    output logic                          frame_irq
);

    localparam int SAW = $clog2(BUF_DEPTH);
    localparam int CHW = 14 - SAW;
    localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t                  state;
    logic                    wr_bank;
    logic [SAW-1:0]          wr_ptr;
    logic                    trig_prev;
    logic                    ready;
    logic                    lock;
    logic [2:0]              ctrl;
    logic [DATA_WIDTH-1:0]   overrun_cnt;

    logic                    wr_access, rd_access, lock_set, trig_hit, cap_we, swap;
    logic                    in_buf, ch_ok, buf_rd;
    logic [CHW-1:0]          ch_full;
    logic [DATA_WIDTH-1:0]   reg_rd_val;
    logic                    unused_wdata;

    assign wr_access = bus_en & bus_we;
    assign rd_access = bus_en & ~bus_we;
    assign lock_set  = wr_access && (bus_addr == ADDR_WIDTH'(ADDR_LOCK)) && bus_wdata[0];
    assign trig_hit  = sample_en & stable & ctrl[2] &
                       edge_match(trig_mode_t'(ctrl[1:0]), trig_in, trig_prev);
    assign cap_we    = ((state == IDLE) && trig_hit) || ((state == CAPTURE) && stable && sample_en);
    // A LOCK=1 write in the swap cycle is honoured first and holds the frame.
    assign swap      = (state == DONE) && !lock && !lock_set;

    assign in_buf  = (bus_addr[ADDR_WIDTH-1:14] == '0);
    assign ch_full = bus_addr[13:SAW];
    assign ch_ok   = ({1'b0, ch_full} < (CHW+1)'(NUM_CH));
    assign buf_rd  = rd_access && in_buf && ch_ok;
    assign unused_wdata = ^bus_wdata[DATA_WIDTH-1:3];

    always_comb begin
        reg_rd_val = '1;
        if (bus_addr == ADDR_WIDTH'(ADDR_STATUS))       reg_rd_val = DATA_WIDTH'({state, lock, ready});
        else if (bus_addr == ADDR_WIDTH'(ADDR_LOCK))    reg_rd_val = DATA_WIDTH'(lock);
        else if (bus_addr == ADDR_WIDTH'(ADDR_CTRL))    reg_rd_val = DATA_WIDTH'(ctrl);
        else if (bus_addr == ADDR_WIDTH'(ADDR_OVERRUN)) reg_rd_val = overrun_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wr_bank     <= 1'b0;
            wr_ptr      <= '0;
            trig_prev   <= 1'b0;
            ready       <= 1'b0;
            lock        <= 1'b0;
            ctrl        <= CTRL_RESET;
            overrun_cnt <= '0;
            frame_irq   <= 1'b0;
        end else begin
            frame_irq <= 1'b0;
            if (sample_en) trig_prev <= trig_in;
            if (wr_access && bus_addr == ADDR_WIDTH'(ADDR_LOCK)) begin
                lock <= bus_wdata[0];
                if (bus_wdata[0] && !lock) ready <= 1'b0;
            end
            if (wr_access && bus_addr == ADDR_WIDTH'(ADDR_CTRL)) ctrl <= bus_wdata[2:0];

            case (state)
                IDLE: begin
                    if (trig_hit) begin
                        state  <= CAPTURE;
                        wr_ptr <= SAW'(1);
                    end
                end
                CAPTURE: begin
                    if (!stable) begin
                        state  <= IDLE;
                        wr_ptr <= '0;
                    end else if (sample_en) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (wr_ptr == SAW'(BUF_DEPTH-1)) state <= DONE;
                    end
                end
                DONE: begin
                    if (swap) begin
                        wr_bank   <= ~wr_bank;
                        ready     <= 1'b1;
                        frame_irq <= 1'b1;
                        wr_ptr    <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (wr_access && bus_addr == ADDR_WIDTH'(ADDR_OVERRUN))
                overrun_cnt <= '0;
            else if (state == DONE && !swap && sample_en && overrun_cnt != '1)
                overrun_cnt <= overrun_cnt + 1'b1;
        end
    end

    // Read path: capture source selection at request time so a later swap cannot change the answer.
    logic                  sel_buf;
    logic                  rd_bank_q;
    logic [CW-1:0]         rd_ch_q;
    logic [DATA_WIDTH-1:0] reg_q;
    logic [ADC_WIDTH-1:0]  ram_q [2][NUM_CH];

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_buf   <= 1'b0;
            rd_bank_q <= 1'b0;
            rd_ch_q   <= '0;
            reg_q     <= '0;
        end else if (rd_access) begin
            sel_buf   <= buf_rd;
            rd_bank_q <= ~wr_bank;
            rd_ch_q   <= ch_full[CW-1:0];
            reg_q     <= reg_rd_val;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            sdp_ram #(.WIDTH(ADC_WIDTH), .DEPTH(BUF_DEPTH)) u_ram (
                .clk   (clk),
                .we    (cap_we && (wr_bank == 1'(b))),
                .waddr (wr_ptr),
                .wdata (adc_data[c*ADC_WIDTH +: ADC_WIDTH]),
                .re    (buf_rd),
                .raddr (bus_addr[SAW-1:0]),
                .rdata (ram_q[b][c])
            );
        end
    end

    assign bus_rdata = sel_buf ? DATA_WIDTH'(ram_q[rd_bank_q][rd_ch_q]) : reg_q;

endmodule

// File: tb/tb_multi_channel_pingpong_capture.sv
// Directed bench for multi_channel_pingpong_capture: read expectations queued at request, checked on response.
module tb_multi_channel_pingpong_capture;

    localparam logic [15:0] A_STATUS = 16'h4000;
    localparam logic [15:0] A_LOCK   = 16'h4001;
    localparam logic [15:0] A_CTRL   = 16'h4002;
    localparam logic [15:0] A_OVR    = 16'h4003;

    logic        clk = 1'b0;
    logic        rst, sample_en, trig_in, stable, bus_en, bus_we;
    logic [23:0] adc_data;
    logic [15:0] bus_addr, bus_wdata, bus_rdata;
    logic        frame_irq;

    int checks = 0, errors = 0;
    int irq_cnt = 0, cyc = 0, irq_at = 0, irq_prev_at = 0;
    logic [15:0] exp_q[$];
    string       tag_q[$];

    multi_channel_pingpong_capture dut (
        .clk(clk), .rst(rst), .sample_en(sample_en), .adc_data(adc_data),
        .trig_in(trig_in), .stable(stable), .bus_en(bus_en), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .frame_irq(frame_irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (frame_irq === 1'b1) begin
            irq_cnt     = irq_cnt + 1;
            irq_prev_at = irq_at;
            irq_at      = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_read(input logic [15:0] a, input logic [15:0] exp, input string tag);
        logic [15:0] e;
        string       t;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        bus_en = 1'b1; bus_we = 1'b0; bus_addr = a;
        @(posedge clk); #1;
        bus_en = 1'b0;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (bus_rdata === e) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", t, bus_rdata, e);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        bus_en = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        @(posedge clk); #1;
        bus_en = 1'b0; bus_we = 1'b0;
    endtask

    task automatic strobe(input logic [11:0] d0, input logic [11:0] d1, input logic t);
        sample_en = 1'b1; adc_data = {d1, d0}; trig_in = t;
        @(posedge clk); #1;
        sample_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; sample_en = 1'b0; trig_in = 1'b0; stable = 1'b1;
        bus_en = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0; adc_data = '0;
        idle(3);
        rst = 1'b0;

        // Reset state
        check("rst_rdata", bus_rdata, 0);
        check("rst_irq", frame_irq, 0);
        bus_read(A_STATUS, 16'h0000, "rst_status");
        bus_read(A_CTRL, 16'h0005, "rst_ctrl");
        bus_read(A_OVR, 16'h0000, "rst_overrun");

        // Rising-edge frame, ch1 carries 0xFFF-i
        strobe(12'd0, 12'd0, 1'b0);
        for (int i = 0; i < 1024; i++) strobe(12'(i), 12'(4095 - i), 1'b1);
        idle(2);
        check("f1_irq", irq_cnt, 1);
        bus_read(A_STATUS, 16'h0001, "f1_status");
        bus_read(16'h0005, 16'h0005, "f1_ch0_5");
        bus_read(16'h0405, 16'h0FFA, "f1_ch1_5");
        bus_read(16'h03FF, 16'h03FF, "f1_ch0_last");

        // Locked second frame: held in DONE, overruns counted, unlock swaps
        bus_write(A_LOCK, 16'h0001);
        bus_read(A_STATUS, 16'h0002, "lock_status");
        strobe(12'd0, 12'd0, 1'b0);
        for (int i = 0; i < 1024; i++) strobe(12'(i + 100), 12'(i + 7), 1'b1);
        idle(2);
        check("f2_held_irq", irq_cnt, 1);
        bus_read(A_STATUS, 16'h000A, "f2_held_status");
        bus_read(16'h0005, 16'h0005, "f2_held_old");
        for (int i = 0; i < 10; i++) strobe(12'd0, 12'd0, 1'b1);
        bus_read(A_OVR, 16'd10, "overrun10");
        bus_write(A_LOCK, 16'h0000);
        idle(2);
        check("f2_irq", irq_cnt, 2);
        bus_read(16'h0005, 16'd105, "f2_ch0_5");
        bus_read(16'h0405, 16'd12, "f2_ch1_5");
        bus_read(A_STATUS, 16'h0001, "f2_status");
        bus_write(A_OVR, 16'h1234);
        bus_read(A_OVR, 16'h0000, "overrun_clr");

        // stable drop mid-frame discards it
        strobe(12'd0, 12'd0, 1'b0);
        for (int i = 0; i < 500; i++) strobe(12'(i + 200), 12'd0, 1'b1);
        stable = 1'b0;
        idle(1);
        stable = 1'b1;
        idle(2);
        check("abort_irq", irq_cnt, 2);
        bus_read(A_STATUS, 16'h0001, "abort_status");
        bus_read(16'h0005, 16'd105, "abort_keep");

        // Falling mode: a rising transition does not trigger
        strobe(12'd0, 12'd0, 1'b0);
        bus_write(A_CTRL, 16'h0006);
        bus_read(A_CTRL, 16'h0006, "ctrl_fall");
        strobe(12'h0AA, 12'd0, 1'b1);
        strobe(12'h0AB, 12'd0, 1'b1);
        bus_read(A_STATUS, 16'h0001, "fall_no_trig");
        for (int i = 0; i < 1024; i++) strobe(12'(16'h300 + i), 12'd0, 1'b0);
        idle(2);
        check("fall_irq", irq_cnt, 3);
        bus_read(16'h0000, 16'h0300, "fall_first");
        bus_read(16'h03FF, 16'h06FF, "fall_last");

        // Free-run: back-to-back frames, one DONE cycle between them
        bus_write(A_CTRL, 16'h0004);
        for (int k = 0; k < 2100; k++) strobe(12'(k), 12'(k), 1'b0);
        idle(2);
        check("free_irq", irq_cnt, 5);
        check("free_period", irq_at - irq_prev_at, 1025);
        bus_read(16'h0000, 16'h0401, "free_first");
        bus_read(16'h03FF, 16'h0800, "free_last");
        bus_write(A_CTRL, 16'h0000);
        bus_read(A_STATUS, 16'h0005, "disable_no_abort");
        stable = 1'b0;
        idle(1);
        stable = 1'b1;
        bus_write(A_CTRL, 16'h0005);

        // LOCK=1 in the swap cycle blocks the swap
        strobe(12'd0, 12'd0, 1'b0);
        for (int i = 0; i < 1024; i++) strobe(12'(16'h500 + i), 12'd0, 1'b1);
        bus_write(A_LOCK, 16'h0001);
        idle(2);
        check("race_irq", irq_cnt, 5);
        bus_read(A_STATUS, 16'h000A, "race_status");
        bus_read(16'h0000, 16'h0401, "race_old_bank");
        bus_read(16'h4004, 16'hFFFF, "unmapped_4004");
        bus_read(16'h0C00, 16'hFFFF, "bad_channel");
        bus_read(16'h8000, 16'hFFFF, "unmapped_8000");
        bus_write(A_STATUS, 16'hFFFF);
        bus_read(A_STATUS, 16'h000A, "status_ro");
        for (int i = 0; i < 3; i++) strobe(12'd0, 12'd0, 1'b1);
        bus_read(A_OVR, 16'd3, "overrun3");
        sample_en = 1'b1; bus_en = 1'b1; bus_we = 1'b1; bus_addr = A_OVR; bus_wdata = 16'h0000;
        @(posedge clk); #1;
        sample_en = 1'b0; bus_en = 1'b0; bus_we = 1'b0;
        bus_read(A_OVR, 16'h0000, "overrun_clear_wins");
        bus_write(A_LOCK, 16'h0000);
        idle(2);
        check("race_irq_after", irq_cnt, 6);
        bus_read(16'h0000, 16'h0500, "race_new_bank");
        bus_read(A_STATUS, 16'h0001, "final_status");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
